// File: rtl/mips_control_pkg.sv
// Shared constants for the MIPS150 main decoder: opcodes, functs, ALU op codes,
// select encodings and the UART I/O address map.
package mips_control_pkg;

    localparam logic [5:0] OpRtype  = 6'h00;
    localparam logic [5:0] OpRegimm = 6'h01;
    localparam logic [5:0] OpJ      = 6'h02;
    localparam logic [5:0] OpJal    = 6'h03;
    localparam logic [5:0] OpBeq    = 6'h04;
    localparam logic [5:0] OpBne    = 6'h05;
    localparam logic [5:0] OpBlez   = 6'h06;
    localparam logic [5:0] OpBgtz   = 6'h07;
    localparam logic [5:0] OpAddiu  = 6'h09;
    localparam logic [5:0] OpSlti   = 6'h0a;
    localparam logic [5:0] OpSltiu  = 6'h0b;
    localparam logic [5:0] OpAndi   = 6'h0c;
    localparam logic [5:0] OpOri    = 6'h0d;
    localparam logic [5:0] OpXori   = 6'h0e;
    localparam logic [5:0] OpLui    = 6'h0f;
    localparam logic [5:0] OpLb     = 6'h20;
    localparam logic [5:0] OpLh     = 6'h21;
    localparam logic [5:0] OpLw     = 6'h23;
    localparam logic [5:0] OpLbu    = 6'h24;
    localparam logic [5:0] OpLhu    = 6'h25;
    localparam logic [5:0] OpSb     = 6'h28;
    localparam logic [5:0] OpSh     = 6'h29;
    localparam logic [5:0] OpSw     = 6'h2b;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2a;
    localparam logic [5:0] FnSltu = 6'h2b;

    localparam logic [3:0] AluAddu = 4'd0;
    localparam logic [3:0] AluSubu = 4'd1;
    localparam logic [3:0] AluSlt  = 4'd2;
    localparam logic [3:0] AluSltu = 4'd3;
    localparam logic [3:0] AluAnd  = 4'd4;
    localparam logic [3:0] AluOr   = 4'd5;
    localparam logic [3:0] AluXor  = 4'd6;
    localparam logic [3:0] AluLui  = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;
    localparam logic [3:0] AluNor  = 4'd11;
    localparam logic [3:0] AluXxx  = 4'd15;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcReg    = 2'b10;
    localparam logic [1:0] PcJump   = 2'b11;

    localparam logic [1:0] SelARs    = 2'b00;
    localparam logic [1:0] SelAPc    = 2'b01;
    localparam logic [1:0] SelAFwd   = 2'b10;
    localparam logic [1:0] SelAShamt = 2'b11;

    localparam logic [1:0] SelBRt   = 2'b00;
    localparam logic [1:0] SelBImm  = 2'b01;
    localparam logic [1:0] SelBFwd  = 2'b10;
    localparam logic [1:0] SelBZimm = 2'b11;

    localparam logic [1:0] UartRx      = 2'b00;
    localparam logic [1:0] UartTxReady = 2'b01;
    localparam logic [1:0] UartRxValid = 2'b10;
    localparam logic [1:0] UartZero    = 2'b11;

    localparam logic [1:0] RdUart = 2'b00;
    localparam logic [1:0] RdAlu  = 2'b01;
    localparam logic [1:0] RdMem  = 2'b10;
    localparam logic [1:0] RdLink = 2'b11;

    localparam logic [3:0]  IoRegion        = 4'b1000;
    localparam logic [31:0] UartTxReadyAddr = 32'h8000_0000;
    localparam logic [31:0] UartRxValidAddr = 32'h8000_0004;
    localparam logic [31:0] UartTxAddr      = 32'h8000_0008;
    localparam logic [31:0] UartRxAddr      = 32'h8000_000c;

    typedef enum logic {StIdle, StActive} state_e;

    // Register written by an instruction, 0 when it writes none.
    function automatic logic [4:0] dest_reg(logic [31:0] instr);
        logic [4:0] dst;
        dst = 5'd0;
        case (instr[31:26])
            OpRtype: if (instr[5:0] != FnJr) dst = instr[15:11];
            OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui,
            OpLb, OpLh, OpLw, OpLbu, OpLhu: dst = instr[20:16];
            OpJal: dst = 5'd31;
            default: dst = 5'd0;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/mips_control_if.sv
// Datapath <-> control bundle: instruction/address/branch in, control selects out.
interface mips_control_if;
    logic [31:0] Instruction;
    logic [31:0] OldInstruction;
    logic [31:0] Address;
    logic        branch;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  PCsel;
    logic [1:0]  AluSelA;
    logic [1:0]  AluSelB;
    logic [3:0]  ALUop;
    logic [3:0]  ByteSel;
    logic        WEIM;
    logic        WEDM;
    logic        REUART;
    logic        WEUART;
    logic [1:0]  UARTsel;
    logic [1:0]  RDsel;

    modport master (
        output Instruction, OldInstruction, Address, branch,
        input  RegWrite, RegDst, PCsel, AluSelA, AluSelB, ALUop, ByteSel,
               WEIM, WEDM, REUART, WEUART, UARTsel, RDsel
    );

    modport slave (
        input  Instruction, OldInstruction, Address, branch,
        output RegWrite, RegDst, PCsel, AluSelA, AluSelB, ALUop, ByteSel,
               WEIM, WEDM, REUART, WEUART, UARTsel, RDsel
    );
endinterface

// File: rtl/mips_control_alu_dec.sv
// ALU operation decoder: opcode + funct to ALU op code.
module mips_control_alu_dec
    import mips_control_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] aluop_o
);
    always_comb begin
        aluop_o = AluAddu;
        case (opcode_i)
            OpRtype: begin
                case (funct_i)
                    FnSll, FnSllv: aluop_o = AluSll;
                    FnSrl, FnSrlv: aluop_o = AluSrl;
                    FnSra, FnSrav: aluop_o = AluSra;
                    FnAddu:        aluop_o = AluAddu;
                    FnSubu:        aluop_o = AluSubu;
                    FnAnd:         aluop_o = AluAnd;
                    FnOr:          aluop_o = AluOr;
                    FnXor:         aluop_o = AluXor;
                    FnNor:         aluop_o = AluNor;
                    FnSlt:         aluop_o = AluSlt;
                    FnSltu:        aluop_o = AluSltu;
                    default:       aluop_o = AluXxx;
                endcase
            end
            OpSlti:  aluop_o = AluSlt;
            OpSltiu: aluop_o = AluSltu;
            OpAndi:  aluop_o = AluAnd;
            OpOri:   aluop_o = AluOr;
            OpXori:  aluop_o = AluXor;
            OpLui:   aluop_o = AluLui;
            // Loads, stores, branches and ADDIU all add.
            default: aluop_o = AluAddu;
        endcase
    end
endmodule

// File: rtl/mips_control.sv
// MIPS150 main decoder: combinational control from the current/previous
// instruction, with side effects held off until the first clock after reset.
module mips_control
    import mips_control_pkg::*;
(
    input logic           Clock,
    input logic           reset,
    mips_control_if.slave bus
);
    state_e     state_q;
    logic       known;
    logic       reg_write, we_im, we_dm, re_uart, we_uart;
    logic [1:0] reg_dst, pc_sel, sel_a, sel_b, uart_sel, rd_sel;
    logic [3:0] byte_sel, aluop;
    logic [4:0] old_dst;
    logic       io;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= StActive;
    end

    mips_control_alu_dec alu_dec (
        .opcode_i (bus.Instruction[31:26]),
        .funct_i  (bus.Instruction[5:0]),
        .aluop_o  (aluop)
    );

    assign io      = bus.Address[31:28] == IoRegion;
    assign old_dst = dest_reg(bus.OldInstruction);

    always_comb begin
        known     = 1'b1;
        reg_write = 1'b0;
        reg_dst   = RegDstRt;
        pc_sel    = PcPlus4;
        sel_a     = SelARs;
        sel_b     = SelBRt;
        byte_sel  = 4'b0000;
        we_im     = 1'b0;
        we_dm     = 1'b0;
        re_uart   = 1'b0;
        we_uart   = 1'b0;
        uart_sel  = UartRx;
        rd_sel    = RdUart;
        case (bus.Instruction[31:26])
            OpRtype: begin
                reg_write = 1'b1;
                reg_dst   = RegDstRd;
                rd_sel    = RdAlu;
                case (bus.Instruction[5:0])
                    FnSll, FnSrl, FnSra: sel_a = SelAShamt;
                    FnJr: begin
                        pc_sel    = PcReg;
                        reg_write = 1'b0;
                    end
                    FnJalr: begin
                        pc_sel = PcReg;
                        rd_sel = RdLink;
                    end
                    default: ;
                endcase
            end
            OpAddiu, OpSlti, OpSltiu: begin
                reg_write = 1'b1;
                rd_sel    = RdAlu;
                sel_b     = SelBImm;
            end
            OpAndi, OpOri, OpXori, OpLui: begin
                reg_write = 1'b1;
                rd_sel    = RdAlu;
                sel_b     = SelBZimm;
            end
            OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
                reg_write = 1'b1;
                sel_b     = SelBImm;
                rd_sel    = io ? RdUart : RdMem;
                re_uart   = bus.Address == UartRxAddr;
                if (io) begin
                    case (bus.Address)
                        UartRxAddr:      uart_sel = UartRx;
                        UartTxReadyAddr: uart_sel = UartTxReady;
                        UartRxValidAddr: uart_sel = UartRxValid;
                        default:         uart_sel = UartZero;
                    endcase
                end
            end
            OpSb, OpSh, OpSw: begin
                sel_b    = SelBImm;
                we_dm    = !bus.Address[31] && bus.Address[28];
                we_im    = !bus.Address[31] && bus.Address[29];
                we_uart  = bus.Address == UartTxAddr;
                uart_sel = io ? UartZero : UartRx;
                case (bus.Instruction[31:26])
                    OpSw:    byte_sel = 4'b1111;
                    OpSh:    byte_sel = bus.Address[1] ? 4'b1100 : 4'b0011;
                    default: byte_sel = 4'b0001 << bus.Address[1:0];
                endcase
            end
            OpRegimm, OpBeq, OpBne, OpBlez, OpBgtz: begin
                sel_a  = SelAPc;
                sel_b  = SelBImm;
                pc_sel = bus.branch ? PcBranch : PcPlus4;
            end
            OpJ: pc_sel = PcJump;
            OpJal: begin
                pc_sel    = PcJump;
                reg_dst   = RegDstRa;
                rd_sel    = RdLink;
                reg_write = 1'b1;
            end
            default: known = 1'b0;
        endcase

        // Bypass the write-back result only where the operand would be register data.
        if (known && old_dst != 5'd0) begin
            if (old_dst == bus.Instruction[25:21] && sel_a == SelARs) sel_a = SelAFwd;
            if (old_dst == bus.Instruction[20:16] && sel_b == SelBRt) sel_b = SelBFwd;
        end

        if (state_q != StActive) begin
            reg_write = 1'b0;
            we_im     = 1'b0;
            we_dm     = 1'b0;
            re_uart   = 1'b0;
            we_uart   = 1'b0;
            byte_sel  = 4'b0000;
            pc_sel    = PcPlus4;
        end
    end

    assign bus.RegWrite = reg_write;
    assign bus.RegDst   = reg_dst;
    assign bus.PCsel    = pc_sel;
    assign bus.AluSelA  = sel_a;
    assign bus.AluSelB  = sel_b;
    assign bus.ALUop    = known ? aluop : 4'd0;
    assign bus.ByteSel  = byte_sel;
    assign bus.WEIM     = we_im;
    assign bus.WEDM     = we_dm;
    assign bus.REUART   = re_uart;
    assign bus.WEUART   = we_uart;
    assign bus.UARTsel  = uart_sel;
    assign bus.RDsel    = rd_sel;
endmodule

// File: tb/tb_mips_control.sv
// Bench for mips_control: directed cases plus random instruction pairs against a
// rule-level reference model.
module tb_mips_control;
    logic Clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic exp_active = 1'b0;

    mips_control_if bus ();

    mips_control dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       rw;
        logic [1:0] dst, pc, sa, sb;
        logic [3:0] alu, bs;
        logic       weim, wedm, reu, weu;
        logic [1:0] us, rd;
    } ctl_t;

    int ops [27] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15,
                     32, 33, 35, 36, 37, 40, 41, 43, 16, 63};
    int fns [16] = '{0, 2, 3, 4, 6, 7, 8, 9, 33, 35, 36, 37, 38, 39, 42, 43};
    logic [31:0] bases [10] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                                32'h0000_0000, 32'h4000_0000, 32'h8000_0000,
                                32'h8000_0004, 32'h8000_0008, 32'h8000_000c,
                                32'h8000_0010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] alu_model(int op, int fn);
        if (op == 0) begin
            if (fn == 0 || fn == 4) return 4'd8;
            if (fn == 2 || fn == 6) return 4'd9;
            if (fn == 3 || fn == 7) return 4'd10;
            case (fn)
                33: return 4'd0;
                35: return 4'd1;
                36: return 4'd4;
                37: return 4'd5;
                38: return 4'd6;
                39: return 4'd11;
                42: return 4'd2;
                43: return 4'd3;
                default: return 4'd15;
            endcase
        end
        case (op)
            10: return 4'd2;
            11: return 4'd3;
            12: return 4'd4;
            13: return 4'd5;
            14: return 4'd6;
            15: return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit is_load(int op);
        return op == 32 || op == 33 || op == 35 || op == 36 || op == 37;
    endfunction

    function automatic ctl_t model(logic [31:0] ins, logic [31:0] old, logic [31:0] a,
                                   logic br, logic act);
        ctl_t c;
        int op, fn, rs, rt, oop, ofn, od, sh;
        bit r, ar_se, ar_ze, ld, st, bq, j, jal, jr, jalr, shift, io;
        op = int'(ins[31:26]); fn = int'(ins[5:0]);
        rs = int'(ins[25:21]); rt = int'(ins[20:16]);
        r = op == 0; ar_se = op >= 9 && op <= 11; ar_ze = op >= 12 && op <= 15;
        ld = is_load(op); st = op == 40 || op == 41 || op == 43;
        bq = op == 1 || (op >= 4 && op <= 7); j = op == 2; jal = op == 3;
        jr = r && fn == 8; jalr = r && fn == 9; shift = r && (fn == 0 || fn == 2 || fn == 3);
        io = a[31:28] == 4'h8;
        c = '0;
        if (!(r || ar_se || ar_ze || ld || st || bq || j || jal)) return c;
        c.rw  = (r && !jr) || ar_se || ar_ze || ld || jal;
        c.dst = r ? 2'd1 : jal ? 2'd2 : 2'd0;
        c.pc  = (jr || jalr) ? 2'd2 : (j || jal) ? 2'd3 : (bq && br) ? 2'd1 : 2'd0;
        c.sa  = shift ? 2'd3 : bq ? 2'd1 : 2'd0;
        c.sb  = ar_ze ? 2'd3 : (ar_se || ld || st || bq) ? 2'd1 : 2'd0;
        c.alu = alu_model(op, fn);
        sh    = op == 41 ? 2 * int'(a[1]) : int'(a[1:0]);
        c.bs  = !st ? 4'd0 : op == 43 ? 4'hf : op == 41 ? 4'(3 << sh) : 4'(1 << sh);
        c.weim = st && !a[31] && a[29];
        c.wedm = st && !a[31] && a[28];
        c.reu  = ld && a == 32'h8000_000c;
        c.weu  = st && a == 32'h8000_0008;
        if ((ld || st) && io) begin
            if (!ld) c.us = 2'd3;
            else if (a == 32'h8000_000c) c.us = 2'd0;
            else if (a == 32'h8000_0000) c.us = 2'd1;
            else if (a == 32'h8000_0004) c.us = 2'd2;
            else c.us = 2'd3;
        end
        c.rd = (jalr || jal) ? 2'd3 : (r || ar_se || ar_ze) ? 2'd1 : ld ? (io ? 2'd0 : 2'd2) : 2'd0;
        oop = int'(old[31:26]); ofn = int'(old[5:0]);
        if (oop == 0 && ofn != 8) od = int'(old[15:11]);
        else if ((oop >= 9 && oop <= 15) || is_load(oop)) od = int'(old[20:16]);
        else if (oop == 3) od = 31;
        else od = 0;
        if (od != 0 && od == rs && c.sa == 2'd0) c.sa = 2'd2;
        if (od != 0 && od == rt && c.sb == 2'd0) c.sb = 2'd2;
        if (!act) begin
            c.rw = 0; c.weim = 0; c.wedm = 0; c.reu = 0; c.weu = 0;
            c.bs = 4'd0; c.pc = 2'd0;
        end
        return c;
    endfunction

    task automatic check_all(input string tag);
        ctl_t e;
        e = model(bus.Instruction, bus.OldInstruction, bus.Address, bus.branch, exp_active);
        check({tag, " RegWrite"}, 32'(bus.RegWrite), 32'(e.rw));
        check({tag, " RegDst"},   32'(bus.RegDst),   32'(e.dst));
        check({tag, " PCsel"},    32'(bus.PCsel),    32'(e.pc));
        check({tag, " AluSelA"},  32'(bus.AluSelA),  32'(e.sa));
        check({tag, " AluSelB"},  32'(bus.AluSelB),  32'(e.sb));
        check({tag, " ALUop"},    32'(bus.ALUop),    32'(e.alu));
        check({tag, " ByteSel"},  32'(bus.ByteSel),  32'(e.bs));
        check({tag, " WEIM"},     32'(bus.WEIM),     32'(e.weim));
        check({tag, " WEDM"},     32'(bus.WEDM),     32'(e.wedm));
        check({tag, " REUART"},   32'(bus.REUART),   32'(e.reu));
        check({tag, " WEUART"},   32'(bus.WEUART),   32'(e.weu));
        check({tag, " UARTsel"},  32'(bus.UARTsel),  32'(e.us));
        check({tag, " RDsel"},    32'(bus.RDsel),    32'(e.rd));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] old,
                         input logic [31:0] a, input logic br);
        @(negedge Clock);
        bus.Instruction = ins; bus.OldInstruction = old; bus.Address = a; bus.branch = br;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        op = 6'(ops[$urandom_range(0, 26)]);
        fn = 6'(fns[$urandom_range(0, 15)]);
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom), fn};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] b;
        b = bases[$urandom_range(0, 9)];
        if (!b[31]) b = b | ($urandom & 32'h0fff_ffff);
        return b;
    endfunction

    task automatic random_phase(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(rand_instr(), ($urandom_range(0, 4) == 0) ? 32'd0 : rand_instr(),
                  rand_addr(), 1'($urandom));
            check_all(tag);
        end
    endtask

    localparam logic [31:0] AdduS0 = {6'd0, 5'd16, 5'd16, 5'd16, 5'd0, 6'h21};
    localparam logic [31:0] AdduZ  = {6'd0, 5'd16, 5'd16, 5'd0, 5'd0, 6'h21};
    localparam logic [31:0] LwS0   = {6'h23, 5'd16, 5'd16, 16'd0};
    localparam logic [31:0] SwS0   = {6'h2b, 5'd16, 5'd16, 16'd0};
    localparam logic [31:0] SbS0   = {6'h28, 5'd16, 5'd16, 16'd0};
    localparam logic [31:0] JalrS0 = {6'd0, 5'd16, 5'd0, 5'd31, 5'd0, 6'h09};
    localparam logic [31:0] BeqS0  = {6'h04, 5'd16, 5'd17, 16'd4};

    initial begin
        bus.Instruction = 32'd0; bus.OldInstruction = 32'd0;
        bus.Address = 32'd0; bus.branch = 1'b0;

        // Held in reset: SW to data memory must not write.
        drive(SwS0, 32'd0, 32'h1000_0000, 1'b0);
        check("rst WEDM", 32'(bus.WEDM), 32'd0);
        check("rst ByteSel", 32'(bus.ByteSel), 32'd0);
        check_all("rst sw");
        @(negedge Clock);
        reset = 1'b1;
        #1 check("rel WEDM", 32'(bus.WEDM), 32'd0);
        @(posedge Clock);
        exp_active = 1'b1;
        #1 check("act WEDM", 32'(bus.WEDM), 32'd1);
        check("act ByteSel", 32'(bus.ByteSel), 32'hf);

        drive(AdduS0, 32'd0, 32'd0, 1'b0);
        check("addu RDsel", 32'(bus.RDsel), 32'd1);
        check("addu RegDst", 32'(bus.RegDst), 32'd1);
        check("addu RegWrite", 32'(bus.RegWrite), 32'd1);
        check("addu Sel", 32'({bus.AluSelA, bus.AluSelB}), 32'd0);
        drive(LwS0, 32'd0, 32'h2000_0000, 1'b0);
        check("lw im WEIM", 32'(bus.WEIM), 32'd0);
        drive(SwS0, 32'd0, 32'h2000_0000, 1'b0);
        check("sw im WEIM", 32'(bus.WEIM), 32'd1);
        drive(LwS0, 32'd0, 32'h1000_0000, 1'b0);
        check("lw dm WEDM", 32'(bus.WEDM), 32'd0);
        check("lw dm RDsel", 32'(bus.RDsel), 32'd2);
        drive(LwS0, 32'd0, 32'h8000_000c, 1'b0);
        check("lw rx REUART", 32'(bus.REUART), 32'd1);
        check("lw rx UARTsel", 32'(bus.UARTsel), 32'd0);
        check("lw rx RDsel", 32'(bus.RDsel), 32'd0);
        drive(SwS0, 32'd0, 32'h8000_0008, 1'b0);
        check("sw tx WEUART", 32'(bus.WEUART), 32'd1);
        drive(JalrS0, 32'd0, 32'd0, 1'b0);
        check("jalr PCsel", 32'(bus.PCsel), 32'd2);
        check("jalr Sel", 32'({bus.AluSelA, bus.AluSelB}), 32'd0);
        check("jalr RegDst", 32'(bus.RegDst), 32'd1);
        drive(BeqS0, 32'd0, 32'd0, 1'b1);
        check("beq t PCsel", 32'(bus.PCsel), 32'd1);
        check("beq t Sel", 32'({bus.AluSelA, bus.AluSelB}), 32'h5);
        drive(BeqS0, 32'd0, 32'd0, 1'b0);
        check("beq n PCsel", 32'(bus.PCsel), 32'd0);
        drive(AdduS0, AdduS0, 32'd0, 1'b0);
        check("fwd Sel", 32'({bus.AluSelA, bus.AluSelB}), 32'ha);
        drive(AdduS0, AdduZ, 32'd0, 1'b0);
        check("fwd0 Sel", 32'({bus.AluSelA, bus.AluSelB}), 32'd0);
        drive(SbS0, 32'd0, 32'h1000_0002, 1'b0);
        check("sb ByteSel", 32'(bus.ByteSel), 32'h4);

        random_phase(400, "rnd");

        // Asynchronous re-entry into reset mid-run.
        @(negedge Clock);
        #2 reset = 1'b0;
        exp_active = 1'b0;
        random_phase(60, "rnd-rst");
        @(negedge Clock);
        reset = 1'b1;
        @(posedge Clock);
        exp_active = 1'b1;
        random_phase(200, "rnd2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_control.md
Name: mips_control

Overview:
- Combinational main decoder for the 3-stage MIPS150 datapath.
- Inputs: the current instruction (`Instruction`), the previous instruction (`OldInstruction`, one stage ahead) and the current effective address.
- Outputs: register-file, ALU-operand, PC, memory, UART and write-back select controls, plus ALU forwarding selects.
- A single state bit gates side effects after reset.

Parameters:
- None. Opcode/funct values come from `Opcode.vh`; ALU operation codes come from `ALUop.vh`.

Ports:
- `Clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Instruction` in 32: current instruction (execute stage).
- `OldInstruction` in 32: previous instruction (write-back stage); 0 = nop.
- `Address` in 32: ALU-computed load/store address of `Instruction`.
- `branch` in 1: comparator result, 1 = branch condition true.
- `RegWrite` out 1: register file write enable.
- `RegDst` out 2: destination select. 00 rt, 01 rd, 10 $31.
- `PCsel` out 2: next-PC select. 00 PC+4, 01 branch target, 10 register (JR/JALR), 11 jump target (J/JAL).
- `AluSelA` out 2: ALU A operand. 00 rs data, 01 PC+4, 10 forwarded write-back value, 11 zero-extended shamt.
- `AluSelB` out 2: ALU B operand. 00 rt data, 01 sign-extended immediate (<<2 for branches), 10 forwarded value, 11 zero-extended immediate.
- `ALUop` out 4: ALU operation code.
- `ByteSel` out 4: store byte-lane mask.
- `WEIM` out 1: instruction memory write enable.
- `WEDM` out 1: data memory write enable.
- `REUART` out 1: UART receive-data read strobe.
- `WEUART` out 1: UART transmit-data write strobe.
- `UARTsel` out 2: UART read mux. 00 rx data, 01 tx-ready status, 10 rx-valid status, 11 zero.
- `RDsel` out 2: write-back mux. 00 UART, 01 ALU, 10 data memory, 11 PC+8 (link).

Behaviour:
- All outputs are combinational from the inputs, gated by the internal bit `active`.
- `active` is cleared asynchronously when `reset` = 0 and set on the first rising `Clock` after `reset` = 1.
- While `active` = 0: `RegWrite`, `WEIM`, `WEDM`, `REUART`, `WEUART` = 0; `ByteSel` = 0000; `PCsel` = 00; all other outputs decode normally.
- R-type: `RegDst` 01, `RDsel` 01, `AluSelA`/`AluSelB` 00/00; `ALUop` is taken from funct.
  - SLL/SRL/SRA: `AluSelA` 11, `AluSelB` 00.
  - JR: `PCsel` 10, no `RegWrite`.
  - JALR: `PCsel` 10, `RegDst` 01, `RDsel` 11, `AluSelA` 00, `AluSelB` 00, `RegWrite` 1.
- I-type arithmetic: `RegDst` 00, `RDsel` 01.
  - ADDIU/SLTI/SLTIU: `AluSelB` 01.
  - ANDI/ORI/XORI/LUI: `AluSelB` 11.
- Loads (LB/LH/LW/LBU/LHU): `RegDst` 00, `AluSelB` 01, `ALUop` ADDU.
  - `RDsel`: 00 if `Address[31:28]`=1000, else 10.
- Stores (SB/SH/SW): no `RegWrite`, `AluSelB` 01, `ALUop` ADDU.
  - `ByteSel`: SW 1111; SH 0011 shifted left by 2*`Address[1]`; SB 0001 shifted left by `Address[1:0]`.
- Branches (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ): `AluSelA` 01, `AluSelB` 01, `ALUop` ADDU, no `RegWrite`. `PCsel` = 01 if `branch` is 1, else 00.
- J: `PCsel` 11. JAL: `PCsel` 11, `RegDst` 10, `RDsel` 11, `RegWrite` 1.
- Memory map, decoded on `Address[31:28]`:
  - Store with bit 31=0 and bit 28=1 asserts `WEDM`.
  - Store with bit 31=0 and bit 29=1 asserts `WEIM` (0011 writes both).
  - 1000 = I/O.
  - Load from 0x8000000C: `REUART`=1, `UARTsel`=00.
  - Load from 0x80000000: `UARTsel`=01. Load from 0x80000004: `UARTsel`=10.
  - Store to 0x80000008: `WEUART`=1.
  - Other I/O addresses: no strobes, `UARTsel` 11.
  - Non-memory instructions never assert memory or UART strobes.
- Forwarding:
  - Old destination: rd for R-type except JR; rt for I-type ALU ops and loads; 31 for JAL; none otherwise.
  - If the old instruction writes a nonzero register equal to current rs, and `AluSelA` would be 00, then `AluSelA` = 10.
  - If it equals current rt and `AluSelB` would be 00, then `AluSelB` = 10.
  - Register $0 is never forwarded.
- Unknown opcode: every output is 0 (`PCsel` 00, no writes).

Decomposition:
- Shared package: opcode/funct constants (`Opcode.vh`), ALU op codes (`ALUop.vh`), select-encoding localparams, I/O address constants.
- One sub-module, `alu_dec` (opcode+funct → `ALUop`).

Test Plan:
- ADDU s0,s0,s0 with `OldInstruction`=nop → `RDsel`=01, `RegDst`=01, `RegWrite`=1, `AluSelA`/`AluSelB`=00.
- LW / SW at `Address` 0x20000000 → `WEIM` 0 / 1. At 0x10000000 → `WEDM` 0 with `RDsel` 10 / `WEDM` 1 with `ByteSel` 1111.
- LW at 0x8000000C → `REUART` 1, `UARTsel` 00, `RDsel` 00. SW at 0x80000008 → `WEUART` 1.
- JALR s0 → `PCsel` 10, `AluSelA`/`AluSelB` 00, `RegDst` 01. BEQ with `branch`=1 → `PCsel` 01, `AluSelA` 01, `AluSelB` 01; with `branch`=0 → `PCsel` 00.
- ADDU s0,s0,s0 after ADDU s0,s0,s0 → `AluSelA`=10, `AluSelB`=10. Same pattern with $0 as destination → 00/00.
- `reset` low during SW to 0x10000000 → `WEDM`=0 until the first `Clock` edge after release; SB at `Address`[1:0]=2 → `ByteSel` 0100.
